// File: rtl/fft_stream_pkg.sv
// Shared types, constants and helper functions for the FFT frame streamer.
package fft_stream_pkg;

  localparam int STAGE_W      = 4;
  localparam int MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Smallest n with 2^n >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Reverse the low 'stage' bits of value; bits above stage come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] value, input logic [STAGE_W-1:0] stage);
    logic [15:0] result;
    logic [15:0] shifted;
    result  = '0;
    shifted = value;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(stage)) begin
        result  = {result[14:0], shifted[0]};
        shifted = shifted >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a 1-cycle registered read.
// A read and write to the same address in one cycle returns the previous contents.
module fft_sample_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              iclk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port and registered read port share the clock edge
  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_streamer.sv
// Frame source for the FFT/IFFT core: buffers per-channel complex frames and streams them
// over valid/ready with first/last markers and a per-run FFT/IFFT mode tag.
module fft_frame_streamer
  import fft_stream_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  MAX_STAGE  = 9,
  parameter int  CHANNELS   = 1,
  localparam int CH_W       = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                  iclk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_chan,
  input  logic [MAX_STAGE-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_real,
  input  logic [DATA_WIDTH-1:0] wr_imag,
  input  logic [STAGE_W-1:0]    iStage,
  input  logic                  iMode,
  input  logic                  iBitrev,
  input  logic                  iLoop,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] oReal,
  output logic [DATA_WIDTH-1:0] oImag,
  output logic [CH_W-1:0]       oChan,
  output logic                  oFirst,
  output logic                  oLast,
  output logic                  oMode,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  err_cfg
);

  // The channel field always occupies CH_W address bits, so the RAM depth is a power of two.
  localparam int ADDR_W = CH_W + MAX_STAGE;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
    logic [CH_W-1:0]       chan;
    logic                  first;
    logic                  last;
    logic                  mode;
  } beat_t;

  state_t                  state;
  logic [STAGE_W-1:0]      cfg_stage;
  logic                    cfg_mode;
  logic                    cfg_bitrev;
  logic                    cfg_loop;
  logic                    stop_req;
  logic [MAX_STAGE-1:0]    idx;
  logic [CH_W-1:0]         chan;

  logic                    rd_valid;
  logic [CH_W-1:0]         rd_chan;
  logic                    rd_first;
  logic                    rd_last;
  logic                    rd_mode;
  logic [2*DATA_WIDTH-1:0] rd_data;
  beat_t                   rd_beat;

  beat_t                   skid_head;
  beat_t                   skid_spare;
  logic [1:0]              skid_count;

  logic                    pop;
  logic                    issue;
  logic [1:0]              occupancy;
  logic                    beat_first;
  logic                    beat_last;
  logic [MAX_STAGE-1:0]    idx_last;
  logic [MAX_STAGE-1:0]    rd_index;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       wr_full_addr;

  assign pop        = o_valid & o_ready;
  // Occupancy after this cycle's pop lets a read issue every cycle while the sink keeps up.
  assign occupancy  = skid_count - {1'b0, pop} + {1'b0, rd_valid};
  assign issue      = (state == ST_RUN) && (occupancy < 2'd2);
  assign idx_last   = MAX_STAGE'((32'd1 << cfg_stage) - 32'd1);
  assign beat_first = (idx == '0) && (chan == '0);
  assign beat_last  = (idx == idx_last) && (chan == CH_W'(CHANNELS - 1));
  assign rd_index   = cfg_bitrev ? MAX_STAGE'(bitrev(16'(idx), cfg_stage)) : idx;
  assign rd_addr    = {chan, rd_index};
  assign wr_full_addr = {wr_chan, wr_addr};
  assign rd_beat    = {rd_data, rd_chan, rd_first, rd_last, rd_mode};

  assign o_valid = (skid_count != 2'd0);
  assign oReal   = skid_head.re;
  assign oImag   = skid_head.im;
  assign oChan   = skid_head.chan;
  assign oFirst  = skid_head.first;
  assign oLast   = skid_head.last;
  assign oMode   = skid_head.mode;
  assign busy    = (state != ST_IDLE);

  fft_sample_ram #(
    .WIDTH  (2 * DATA_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .iclk    (iclk),
    .wr_en   (wr_en),
    .wr_addr (wr_full_addr),
    .wr_data ({wr_real, wr_imag}),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Control FSM, beat counters, read-pipe tag and frame accounting
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cfg_stage  <= '0;
      cfg_mode   <= 1'b0;
      cfg_bitrev <= 1'b0;
      cfg_loop   <= 1'b0;
      stop_req   <= 1'b0;
      idx        <= '0;
      chan       <= '0;
      rd_valid   <= 1'b0;
      rd_chan    <= '0;
      rd_first   <= 1'b0;
      rd_last    <= 1'b0;
      rd_mode    <= 1'b0;
      frame_cnt  <= '0;
      err_cfg    <= 1'b0;
    end else begin
      err_cfg  <= 1'b0;
      rd_valid <= issue;
      if (issue) begin
        rd_chan  <= chan;
        rd_first <= beat_first;
        rd_last  <= beat_last;
        rd_mode  <= cfg_mode;
      end
      if (pop && oLast) frame_cnt <= frame_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (iStage == '0 || int'(iStage) > MAX_STAGE) begin
              err_cfg <= 1'b1;
            end else begin
              cfg_stage  <= iStage;
              cfg_mode   <= iMode;
              cfg_bitrev <= iBitrev;
              cfg_loop   <= iLoop;
              stop_req   <= 1'b0;
              idx        <= '0;
              chan       <= '0;
              frame_cnt  <= '0;
              state      <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (stop) stop_req <= 1'b1;
          if (issue) begin
            if (beat_last) begin
              idx  <= '0;
              chan <= '0;
              if (!cfg_loop || stop || stop_req) begin
                stop_req <= 1'b0;
                state    <= ST_DRAIN;
              end
            end else if (chan == CH_W'(CHANNELS - 1)) begin
              chan <= '0;
              idx  <= idx + MAX_STAGE'(1);
            end else begin
              chan <= chan + CH_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!rd_valid && (skid_count == 2'd0 || (skid_count == 2'd1 && pop))) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry skid buffer; the head entry drives the output ports directly
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      skid_head  <= '0;
      skid_spare <= '0;
      skid_count <= 2'd0;
    end else begin
      case ({rd_valid, pop})
        2'b11: begin
          if (skid_count == 2'd2) begin
            skid_head  <= skid_spare;
            skid_spare <= rd_beat;
          end else begin
            skid_head <= rd_beat;
          end
        end
        2'b10: begin
          if (skid_count == 2'd0) skid_head <= rd_beat;
          else skid_spare <= rd_beat;
          skid_count <= skid_count + 2'd1;
        end
        2'b01: begin
          if (skid_count == 2'd2) skid_head <= skid_spare;
          skid_count <= skid_count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Self-checking bench for fft_frame_streamer with two interleaved channels.
module tb_fft_frame_streamer;

  localparam int DW = 16;
  localparam int MS = 9;
  localparam int CH = 2;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        chan;
    logic        first;
    logic        last;
    logic        mode;
  } beat_t;

  logic          iclk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [0:0]    wr_chan;
  logic [MS-1:0] wr_addr;
  logic [DW-1:0] wr_real;
  logic [DW-1:0] wr_imag;
  logic [3:0]    iStage;
  logic          iMode;
  logic          iBitrev;
  logic          iLoop;
  logic          start;
  logic          stop;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] oReal;
  logic [DW-1:0] oImag;
  logic [0:0]    oChan;
  logic          oFirst;
  logic          oLast;
  logic          oMode;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_cfg;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          model_frames = 0;
  bit          mon_en = 1'b0;
  bit          held_prev = 1'b0;
  beat_t       held_beat;
  beat_t       exp_q[$];
  beat_t       act_log[$];
  int          act_cycle[$];
  logic [15:0] mem_re [CH][1 << MS];
  logic [15:0] mem_im [CH][1 << MS];

  fft_frame_streamer #(
    .DATA_WIDTH (DW),
    .MAX_STAGE  (MS),
    .CHANNELS   (CH)
  ) dut (
    .iclk      (iclk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_chan   (wr_chan),
    .wr_addr   (wr_addr),
    .wr_real   (wr_real),
    .wr_imag   (wr_imag),
    .iStage    (iStage),
    .iMode     (iMode),
    .iBitrev   (iBitrev),
    .iLoop     (iLoop),
    .start     (start),
    .stop      (stop),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .oReal     (oReal),
    .oImag     (oImag),
    .oChan     (oChan),
    .oFirst    (oFirst),
    .oLast     (oLast),
    .oMode     (oMode),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cfg   (err_cfg)
  );

  always #5 iclk = ~iclk;

  // Free-running cycle counter used to measure throughput
  always @(posedge iclk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic write_sample(input int ch, input int k, input logic [15:0] re, input logic [15:0] im);
    tick();
    wr_en   = 1'b1;
    wr_chan = 1'(ch);
    wr_addr = MS'(k);
    wr_real = re;
    wr_imag = im;
    mem_re[ch][k] = re;
    mem_im[ch][k] = im;
  endtask

  // Expected beat stream: index outer, channel inner, address optionally bit-reversed
  task automatic build_model(input int stage, input bit mode, input bit rev, input int frames);
    int n;
    int addr;
    beat_t bt;
    n = 1 << stage;
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < n; k++) begin
        addr = k;
        if (rev) begin
          addr = 0;
          for (int bb = 0; bb < stage; bb++) addr = addr * 2 + ((k >> bb) & 1);
        end
        for (int ch = 0; ch < CH; ch++) begin
          bt.re    = mem_re[ch][addr];
          bt.im    = mem_im[ch][addr];
          bt.chan  = 1'(ch);
          bt.first = (k == 0) && (ch == 0);
          bt.last  = (k == n - 1) && (ch == CH - 1);
          bt.mode  = mode;
          exp_q.push_back(bt);
        end
      end
    end
  endtask

  task automatic clear_logs();
    act_log.delete();
    act_cycle.delete();
    model_frames = 0;
  endtask

  // Issue a start pulse; returns one ns after the edge that samples it
  task automatic apply_stimulus(input int stage, input bit mode, input bit rev, input bit loop, input int frames);
    tick();
    if (stage >= 1 && stage <= MS) build_model(stage, mode, rev, frames);
    iStage  = 4'(stage);
    iMode   = mode;
    iBitrev = rev;
    iLoop   = loop;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_output("done_in_budget", 64'(exp_q.size()), 0);
    check_output("idle_after_done", busy, 0);
    check_output("valid_low_after_done", o_valid, 0);
  endtask

  // Compare every transferred beat against the model and watch stall stability
  always @(negedge iclk) begin : monitor
    beat_t cur;
    beat_t expb;
    cur = '{re: oReal, im: oImag, chan: oChan, first: oFirst, last: oLast, mode: oMode};
    if (mon_en && rstn) begin
      if (held_prev) begin
        check_output("stall_valid_held", o_valid, 1);
        check_output("stall_beat_held", cur, held_beat);
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_beat", o_valid, 0);
        end else begin
          expb = exp_q.pop_front();
          check_output("beat", cur, expb);
        end
        act_log.push_back(cur);
        act_cycle.push_back(cycle);
        if (oLast) model_frames++;
      end else if (o_valid && exp_q.size() == 0) begin
        check_output("spurious_valid", o_valid, 0);
      end
      held_prev = o_valid && !o_ready;
      held_beat = cur;
    end else begin
      held_prev = 1'b0;
    end
  end

  int br_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int t3_exp [8] = '{0, 100, 1, 101, 2, 102, 3, 103};

  initial begin : main
    int n;
    bit stopped;
    rstn = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_addr = '0; wr_real = '0; wr_imag = '0;
    iStage = '0; iMode = 1'b0; iBitrev = 1'b0; iLoop = 1'b0; start = 1'b0; stop = 1'b0;
    o_ready = 1'b1;
    repeat (3) tick();
    @(negedge iclk);
    check_output("reset_valid", o_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_frame_cnt", frame_cnt, 0);
    check_output("reset_err_cfg", err_cfg, 0);
    check_output("reset_data", {oReal, oImag, oChan, oFirst, oLast, oMode}, 0);
    tick();
    rstn = 1'b1;
    mon_en = 1'b1;

    $display("[TB] loading buffer: ch0 = {k,-k}, ch1 = {100+k,-(100+k)}");
    for (int k = 0; k < 64; k++) begin
      write_sample(0, k, 16'(k), 16'(-k));
      write_sample(1, k, 16'(100 + k), 16'(-(100 + k)));
    end
    tick();
    wr_en = 1'b0;

    $display("[TB] test 1: stage 6, natural order, ready high");
    clear_logs();
    apply_stimulus(6, 1'b0, 1'b0, 1'b0, 1);
    check_output("t1_busy_after_start", busy, 1);
    @(negedge iclk);
    check_output("t1_latency_edge_t", o_valid, 0);
    @(negedge iclk);
    check_output("t1_latency_edge_t1", o_valid, 0);
    @(negedge iclk);
    check_output("t1_latency_edge_t2", o_valid, 1);
    wait_done(400);
    check_output("t1_beat_count", 64'(act_log.size()), 128);
    if (act_log.size() == 128) begin
      check_output("t1_first_re", act_log[0].re, 0);
      check_output("t1_first_flag", act_log[0].first, 1);
      check_output("t1_ch1_re", act_log[1].re, 100);
      check_output("t1_ch1_chan", act_log[1].chan, 1);
      check_output("t1_im_neg1", act_log[2].im, 16'hFFFF);
      check_output("t1_last_re", act_log[127].re, 163);
      check_output("t1_last_flag", act_log[127].last, 1);
      check_output("t1_no_bubbles", 64'(act_cycle[127] - act_cycle[0]), 127);
    end
    check_output("t1_frame_cnt", frame_cnt, 1);

    $display("[TB] test 2: stage 3, bit-reversed, IFFT tag");
    clear_logs();
    apply_stimulus(3, 1'b1, 1'b1, 1'b0, 1);
    wait_done(200);
    check_output("t2_beat_count", 64'(act_log.size()), 16);
    if (act_log.size() == 16) begin
      for (int i = 0; i < 8; i++) check_output("t2_bitrev_order", act_log[2 * i].re, 64'(br_exp[i]));
      check_output("t2_ch1_re", act_log[1].re, 100);
      check_output("t2_mode_tag", act_log[0].mode, 1);
    end

    $display("[TB] test 3: stage 2, two channels interleaved");
    clear_logs();
    apply_stimulus(2, 1'b0, 1'b0, 1'b0, 1);
    wait_done(100);
    check_output("t3_beat_count", 64'(act_log.size()), 8);
    if (act_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_output("t3_re", act_log[i].re, 64'(t3_exp[i]));
        check_output("t3_chan", act_log[i].chan, 64'(i % 2));
        check_output("t3_last", act_log[i].last, 64'(i == 7));
      end
    end

    $display("[TB] test 4: looped stage 6, random ready, stop in frame 3");
    clear_logs();
    apply_stimulus(6, 1'b0, 1'b0, 1'b1, 3);
    stopped = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin
      o_ready = 1'($urandom_range(0, 1));
      stop = 1'b0;
      if (!stopped && act_log.size() >= 2 * 128 + 60) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
      tick();
      n++;
    end
    stop = 1'b0;
    o_ready = 1'b1;
    wait_done(50);
    check_output("t4_beat_count", 64'(act_log.size()), 384);
    if (act_log.size() == 384) check_output("t4_final_is_last", act_log[383].last, 1);
    check_output("t4_frames_seen", 64'(model_frames), 3);
    check_output("t4_frame_cnt", frame_cnt, 3);

    $display("[TB] test 5: illegal stage values");
    clear_logs();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1);
    @(negedge iclk);
    check_output("t5_err_stage0", err_cfg, 1);
    check_output("t5_busy_stage0", busy, 0);
    @(negedge iclk);
    check_output("t5_err_stage0_clears", err_cfg, 0);
    apply_stimulus(MS + 1, 1'b0, 1'b0, 1'b0, 1);
    @(negedge iclk);
    check_output("t5_err_stage_big", err_cfg, 1);
    check_output("t5_busy_stage_big", busy, 0);
    @(negedge iclk);
    check_output("t5_err_big_clears", err_cfg, 0);
    repeat (4) tick();
    check_output("t5_no_valid", o_valid, 0);
    check_output("t5_no_beats", 64'(act_log.size()), 0);

    $display("[TB] test 6: reset in mid-frame, then restart");
    clear_logs();
    apply_stimulus(6, 1'b0, 1'b0, 1'b0, 1);
    n = 0;
    while (act_log.size() < 20 && n < 200) begin
      tick();
      n++;
    end
    check_output("t6_reached_beat20", 64'(act_log.size() >= 20), 1);
    mon_en = 1'b0;
    rstn = 1'b0;
    exp_q.delete();
    @(posedge iclk);
    @(negedge iclk);
    check_output("t6_valid_after_reset", o_valid, 0);
    check_output("t6_busy_after_reset", busy, 0);
    check_output("t6_frame_cnt_after_reset", frame_cnt, 0);
    tick();
    rstn = 1'b1;
    mon_en = 1'b1;
    clear_logs();
    apply_stimulus(6, 1'b0, 1'b0, 1'b0, 1);
    check_output("t6_frame_cnt_fresh", frame_cnt, 0);
    wait_done(400);
    check_output("t6_beat_count", 64'(act_log.size()), 128);
    if (act_log.size() > 0) begin
      check_output("t6_restart_re", act_log[0].re, 0);
      check_output("t6_restart_first", act_log[0].first, 1);
    end
    check_output("t6_frame_cnt_done", frame_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
